// File: rtl/track_pkg.sv
// Shared tracking-channel definitions: FSM state encoding, default widths and
// the 3-bit sign-magnitude sample decoder.
package track_pkg;

  localparam int ACC_WIDTH_DEF = 18;
  localparam int CNT_WIDTH_DEF = 15;
  localparam int CA_CHIPS      = 1023;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SYNC  = 2'd1,
    ACCUM = 2'd2
  } state_t;

  // Odd-magnitude mapping: mag 0..3 -> 1,3,5,7, sign bit negates.
  function automatic logic signed [ACC_WIDTH_DEF-1:0] sm3_to_signed(input logic [2:0] s);
    logic signed [ACC_WIDTH_DEF-1:0] mag;
    mag = {{(ACC_WIDTH_DEF-3){1'b0}}, s[1:0], 1'b1};
    return s[2] ? -mag : mag;
  endfunction

endpackage

// File: rtl/sat_adder.sv
// Signed two-operand adder that clamps to the representable range and flags
// when the clamp was applied.
module sat_adder #(
  parameter int W = 18
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                sat
);

  localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic [W:0] full;

  // One extra bit: overflow shows as disagreement of the top two bits.
  assign full = {a[W-1], a} + {b[W-1], b};
  assign sat  = full[W] ^ full[W-1];

  always_comb begin
    sum = full[W-1:0];
    if (sat) sum = full[W] ? MIN_VAL : MAX_VAL;
  end

endmodule

// File: rtl/accum_dump.sv
// Per-channel integrate-and-dump: sums wiped samples over EPOCHS_PER_DUMP code
// epochs and hands the sum/count to the loop processor via valid/ready.
module accum_dump
  import track_pkg::*;
#(
  parameter int ACC_WIDTH       = ACC_WIDTH_DEF,
  parameter int CNT_WIDTH       = CNT_WIDTH_DEF,
  parameter int EPOCHS_PER_DUMP = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 sample_valid,
  input  logic [2:0]           sample,
  input  logic                 epoch,
  input  logic                 dump_ready,
  output logic                 dump_valid,
  output logic [ACC_WIDTH-1:0] dump_value,
  output logic [CNT_WIDTH-1:0] dump_count,
  output logic                 dump_sat,
  output logic                 dump_missed,
  output logic [1:0]           fsm_state
);

  // Handshake: a dump transfers on any cycle where dump_valid and dump_ready
  // are both high; while valid is high and ready low the dump_* outputs hold.

  localparam logic [4:0]           EP_LAST = 5'(EPOCHS_PER_DUMP - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  state_t                       state;
  logic signed [ACC_WIDTH-1:0]  acc;
  logic [CNT_WIDTH-1:0]         cnt;
  logic [4:0]                   epoch_cnt;
  logic                         sat_flag;

  logic signed [ACC_WIDTH-1:0]  sample_value;
  logic signed [ACC_WIDTH-1:0]  add_sum;
  logic                         add_sat;
  logic                         terminal;
  logic                         dump_take;

  assign sample_value = ACC_WIDTH'(sm3_to_signed(sample));
  assign fsm_state    = state;

  sat_adder #(.W(ACC_WIDTH)) u_add (
    .a   (acc),
    .b   (sample_value),
    .sum (add_sum),
    .sat (add_sat)
  );

  // enable low wins over everything, so an aborting cycle never dumps.
  assign terminal  = enable && (state == ACCUM) && epoch && (epoch_cnt == EP_LAST);
  assign dump_take = terminal && (!dump_valid || dump_ready);

  always_ff @(posedge clk) begin
    if (!reset) begin
      dump_valid  <= 1'b0;
      dump_value  <= '0;
      dump_count  <= '0;
      dump_sat    <= 1'b0;
      dump_missed <= 1'b0;
    end else begin
      if (dump_take) begin
        dump_valid <= 1'b1;
        dump_value <= acc;
        dump_count <= cnt;
        dump_sat   <= sat_flag;
      end else if (dump_valid && dump_ready) begin
        dump_valid <= 1'b0;
      end
      if (terminal && !dump_take) dump_missed <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      epoch_cnt <= '0;
      sat_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= SYNC;
        end
        SYNC: begin
          if (epoch) begin
            state     <= ACCUM;
            acc       <= '0;
            cnt       <= '0;
            epoch_cnt <= '0;
            sat_flag  <= 1'b0;
          end
        end
        ACCUM: begin
          if (terminal) begin
            // A sample coinciding with the terminal epoch opens the new period.
            acc       <= sample_valid ? sample_value : '0;
            cnt       <= sample_valid ? CNT_WIDTH'(1) : '0;
            epoch_cnt <= '0;
            sat_flag  <= 1'b0;
          end else begin
            if (epoch) epoch_cnt <= epoch_cnt + 5'd1;
            if (sample_valid) begin
              acc      <= add_sum;
              sat_flag <= sat_flag | add_sat;
              if (cnt != CNT_MAX) cnt <= cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accum_dump.sv
// Bench for accum_dump: two instances (18-bit/N=1 and 8-bit/N=3) share the
// stimulus and are checked every cycle against an integer behavioural model.
module tb_accum_dump;
  import track_pkg::*;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       sample_valid;
  logic [2:0] sample;
  logic       epoch;
  logic       dump_ready;

  logic        d0_valid, d0_sat, d0_missed;
  logic [17:0] d0_value;
  logic [14:0] d0_count;
  logic [1:0]  d0_state;

  logic        d1_valid, d1_sat, d1_missed;
  logic [7:0]  d1_value;
  logic [14:0] d1_count;
  logic [1:0]  d1_state;

  accum_dump #(.ACC_WIDTH(18), .CNT_WIDTH(15), .EPOCHS_PER_DUMP(1)) u_dut0 (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .sample(sample), .epoch(epoch), .dump_ready(dump_ready),
    .dump_valid(d0_valid), .dump_value(d0_value), .dump_count(d0_count),
    .dump_sat(d0_sat), .dump_missed(d0_missed), .fsm_state(d0_state)
  );

  accum_dump #(.ACC_WIDTH(8), .CNT_WIDTH(15), .EPOCHS_PER_DUMP(3)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
    .sample(sample), .epoch(epoch), .dump_ready(dump_ready),
    .dump_valid(d1_valid), .dump_value(d1_value), .dump_count(d1_count),
    .dump_sat(d1_sat), .dump_missed(d1_missed), .fsm_state(d1_state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int aw[2]   = '{18, 8};
  int n_ep[2] = '{1, 3};
  int m_st[2], m_acc[2], m_cnt[2], m_ep[2], m_sat[2];
  int m_dv[2], m_dval[2], m_dcnt[2], m_dsat[2], m_dmiss[2];

  int n_cmp = 0;
  int n_err = 0;
  bit checking = 1'b0;

  function automatic int map3(input logic [2:0] s);
    int mag;
    mag = 2 * int'(s[1:0]) + 1;
    return s[2] ? -mag : mag;
  endfunction

  task automatic model_step(input int k);
    int v, mx, mn, sum, cmax, nv;
    mx   = (1 << (aw[k] - 1)) - 1;
    mn   = -(1 << (aw[k] - 1));
    cmax = (1 << 15) - 1;
    v    = sample_valid ? map3(sample) : 0;
    if (!reset) begin
      m_st[k] = int'(IDLE); m_acc[k] = 0; m_cnt[k] = 0; m_ep[k] = 0; m_sat[k] = 0;
      m_dv[k] = 0; m_dval[k] = 0; m_dcnt[k] = 0; m_dsat[k] = 0; m_dmiss[k] = 0;
    end else begin
      nv = (m_dv[k] != 0 && dump_ready) ? 0 : m_dv[k];
      if (!enable) begin
        m_st[k] = int'(IDLE); m_acc[k] = 0; m_cnt[k] = 0; m_ep[k] = 0; m_sat[k] = 0;
      end else if (m_st[k] == int'(IDLE)) begin
        m_st[k] = int'(SYNC);
      end else if (m_st[k] == int'(SYNC)) begin
        if (epoch) begin
          m_st[k] = int'(ACCUM); m_acc[k] = 0; m_cnt[k] = 0; m_ep[k] = 0; m_sat[k] = 0;
        end
      end else if (epoch && m_ep[k] == n_ep[k] - 1) begin
        if (m_dv[k] == 0 || dump_ready) begin
          nv = 1; m_dval[k] = m_acc[k]; m_dcnt[k] = m_cnt[k]; m_dsat[k] = m_sat[k];
        end else begin
          m_dmiss[k] = 1;
        end
        m_acc[k] = v; m_cnt[k] = sample_valid ? 1 : 0; m_ep[k] = 0; m_sat[k] = 0;
      end else begin
        if (epoch) m_ep[k] = m_ep[k] + 1;
        if (sample_valid) begin
          sum = m_acc[k] + v;
          if (sum > mx) begin sum = mx; m_sat[k] = 1; end
          if (sum < mn) begin sum = mn; m_sat[k] = 1; end
          m_acc[k] = sum;
          if (m_cnt[k] < cmax) m_cnt[k] = m_cnt[k] + 1;
        end
      end
      m_dv[k] = nv;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checking) begin
      chk("d0_valid",  int'(d0_valid),          m_dv[0]);
      chk("d0_value",  int'($signed(d0_value)), m_dval[0]);
      chk("d0_count",  int'(d0_count),          m_dcnt[0]);
      chk("d0_sat",    int'(d0_sat),            m_dsat[0]);
      chk("d0_missed", int'(d0_missed),         m_dmiss[0]);
      chk("d0_state",  int'(d0_state),          m_st[0]);
      chk("d1_valid",  int'(d1_valid),          m_dv[1]);
      chk("d1_value",  int'($signed(d1_value)), m_dval[1]);
      chk("d1_count",  int'(d1_count),          m_dcnt[1]);
      chk("d1_sat",    int'(d1_sat),            m_dsat[1]);
      chk("d1_missed", int'(d1_missed),         m_dmiss[1]);
      chk("d1_state",  int'(d1_state),          m_st[1]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
    #1;
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic sv, input logic [2:0] s, input logic ep);
    sample_valid = sv;
    sample       = s;
    epoch        = ep;
    tick();
  endtask

  task automatic run_samples(input int n, input logic [2:0] s);
    for (int i = 0; i < n; i++) cyc(1'b1, s, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b0; enable = 1'b0; sample_valid = 1'b0; sample = '0;
    epoch = 1'b0; dump_ready = 1'b0;

    // Reset held for 3 clocks with random inputs.
    for (int i = 0; i < 3; i++) begin
      enable = 1'($urandom); sample_valid = 1'($urandom); sample = 3'($urandom);
      epoch = 1'($urandom); dump_ready = 1'($urandom);
      tick();
      checking = 1'b1;
    end
    chk("rst_valid",  int'(d0_valid), 0);
    chk("rst_value",  int'(d0_value), 0);
    chk("rst_count",  int'(d0_count), 0);
    chk("rst_missed", int'(d0_missed), 0);
    chk("rst_state",  int'(d0_state), 0);

    // Enable: IDLE -> SYNC; samples in SYNC are ignored; epoch only enters ACCUM.
    reset = 1'b1; enable = 1'b1; dump_ready = 1'b1;
    cyc(1'b0, 3'b000, 1'b0);
    chk("sync_state", int'(d0_state), 1);
    cyc(1'b1, 3'b011, 1'b0);
    cyc(1'b1, 3'b011, 1'b0);
    cyc(1'b1, 3'b011, 1'b1);
    chk("accum_state", int'(d0_state), 2);
    chk("first_epoch_no_dump", int'(d0_valid), 0);

    // Single dump of 16800 x (+7).
    run_samples(16800, 3'b011);
    cyc(1'b0, 3'b000, 1'b1);
    chk("t2_valid", int'(d0_valid), 1);
    chk("t2_value", int'($signed(d0_value)), 117600);
    chk("t2_count", int'(d0_count), 16800);
    chk("t2_sat",   int'(d0_sat), 0);
    cyc(1'b0, 3'b000, 1'b0);
    chk("t2_drain", int'(d0_valid), 0);

    // Sample coinciding with the epoch belongs to the new period.
    cyc(1'b1, 3'b100, 1'b1);
    run_samples(9, 3'b001);
    cyc(1'b0, 3'b000, 1'b1);
    chk("t3_value", int'($signed(d0_value)), 26);
    chk("t3_count", int'(d0_count), 10);

    // 8-bit instance over three epochs: 40 x (+7) clamps to 127.
    run_samples(20, 3'b011);
    cyc(1'b0, 3'b000, 1'b1);
    run_samples(20, 3'b011);
    cyc(1'b0, 3'b000, 1'b1);
    cyc(1'b0, 3'b000, 1'b1);
    chk("t4_valid", int'(d1_valid), 1);
    chk("t4_value", int'($signed(d1_value)), 127);
    chk("t4_count", int'(d1_count), 40);
    chk("t4_sat",   int'(d1_sat), 1);
    cyc(1'b1, 3'b000, 1'b0);
    cyc(1'b0, 3'b000, 1'b1);
    cyc(1'b1, 3'b000, 1'b0);
    cyc(1'b0, 3'b000, 1'b1);
    cyc(1'b0, 3'b000, 1'b1);
    chk("t4b_value", int'($signed(d1_value)), 2);
    chk("t4b_count", int'(d1_count), 2);
    chk("t4b_sat",   int'(d1_sat), 0);
    cyc(1'b0, 3'b000, 1'b0);

    // Backpressure: hold first result, drop second, then back-to-back reload.
    dump_ready = 1'b0;
    run_samples(5, 3'b010);
    cyc(1'b0, 3'b000, 1'b1);
    chk("t5_value", int'($signed(d0_value)), 25);
    run_samples(4, 3'b101);
    chk("t5_hold", int'($signed(d0_value)), 25);
    cyc(1'b0, 3'b000, 1'b1);
    chk("t5_missed", int'(d0_missed), 1);
    chk("t5_kept",   int'(d0_count), 5);
    run_samples(3, 3'b000);
    dump_ready = 1'b1;
    cyc(1'b0, 3'b000, 1'b1);
    chk("t5_b2b_valid", int'(d0_valid), 1);
    chk("t5_b2b_value", int'($signed(d0_value)), 3);

    // Abort mid-integration; pending dump survives, SYNC needed again.
    dump_ready = 1'b0;
    run_samples(4, 3'b011);
    enable = 1'b0;
    cyc(1'b0, 3'b000, 1'b0);
    chk("t6_idle",    int'(d0_state), 0);
    chk("t6_pending", int'(d0_valid), 1);
    enable = 1'b1;
    cyc(1'b0, 3'b000, 1'b0);
    cyc(1'b0, 3'b000, 1'b1);
    chk("t6_no_dump", int'($signed(d0_value)), 3);
    run_samples(2, 3'b011);
    cyc(1'b0, 3'b000, 1'b1);
    chk("t6_still", int'(d0_count), 3);
    dump_ready = 1'b1;
    cyc(1'b0, 3'b000, 1'b0);
    chk("t6_drain", int'(d0_valid), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) != 0);
      enable     = ($urandom_range(0, 49) != 0);
      dump_ready = 1'($urandom);
      cyc(($urandom_range(0, 9) < 7), 3'($urandom), ($urandom_range(0, 19) == 0));
    end

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
